mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between instruction fetch (IF) and load/store (LS) in riscv_top.
- Grants at most one request per cycle and forwards it to the memory.
- Routes the one-cycle-latency read data back to whichever requester owned the access.
- LS has fixed priority; a starvation guard ensures fetch progress.
- Keeps a saturating conflict counter for debug.

---
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// LS has fixed priority; a starvation guard periodically lets IF through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  // Stores are tracked separately so their completion returns zero data.
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]       starve_q, starve_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             both;

  always_comb begin
    both   = if_req & ls_req;
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    // Grants are combinational, so they are gated by reset explicitly.
    if (rst) begin
      if (ls_req && !(if_req && starve_q == STARVE_LIM)) ls_gnt = 1'b1;
      else if (if_req)                                   if_gnt = 1'b1;
    end
    mem_req   = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_be   = '1;
      mem_addr = if_addr;
    end

    if (!if_req || if_gnt)          starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
    else                            starve_d = starve_q;

    if (if_gnt)      owner_d = OWN_IF;
    else if (ls_gnt) owner_d = ls_we ? OWN_ST : OWN_LD;
    else             owner_d = OWN_NONE;

    cnt_d = (both && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      cnt_q    <= '0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign if_rvalid    = (owner_q == OWN_IF);
  assign ls_rvalid    = (owner_q == OWN_LD) || (owner_q == OWN_ST);
  assign if_rdata     = if_rvalid ? mem_rdata : '0;
  assign ls_rdata     = (owner_q == OWN_LD) ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected responses are queued at grant time
// and popped by a monitor when an rvalid appears.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SM = 4, CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [3:0]    ls_be, mem_be;
  logic          if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1357_9BDF;
  endfunction

  // Memory: one-cycle read latency; returns junk when not accessed.
  always @(posedge clk) mem_rdata <= mem_req ? memf(mem_addr) : 32'hBAD0_0BAD;

  typedef struct {bit is_if; logic [31:0] data;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (if_rvalid || ls_rvalid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected if_rvalid=%0b ls_rvalid=%0b required none", if_rvalid, ls_rvalid);
        end else begin
          mon_e = q.pop_front();
          if (if_rvalid !== mon_e.is_if || ls_rvalid !== !mon_e.is_if ||
              (mon_e.is_if ? if_rdata : ls_rdata) !== mon_e.data) begin
            n_bad++;
            $display("FAIL rsp_route if_rvalid=%0b ls_rvalid=%0b if_rdata=%h ls_rdata=%h required is_if=%0b data=%h",
                     if_rvalid, ls_rvalid, if_rdata, ls_rdata, mon_e.is_if, mon_e.data);
          end
        end
      end
      n_cmp++;
      if ((!if_rvalid && if_rdata !== '0) || (!ls_rvalid && ls_rdata !== '0)) begin
        n_bad++;
        $display("FAIL rdata_idle if_rdata=%h ls_rdata=%h required 0 when not valid", if_rdata, ls_rdata);
      end
    end
  end

  task automatic set_in(input bit ir, input logic [31:0] ia, input bit lr, input bit we,
                        input logic [3:0] be, input logic [31:0] la, input logic [31:0] wd);
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = we; ls_be = be; ls_addr = la; ls_wdata = wd;
  endtask

  task automatic pulse_reset;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending responses_left=%0d required 0", name, q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_in(1, 32'h40, 1, 1, 4'hF, 32'h80, 32'h55);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_req, mem_we, if_rvalid, ls_rvalid} !== 6'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || mem_be !== '0 || conflict_cnt !== '0 || if_rdata !== '0 || ls_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_hold gnt=%0b%0b mem_req=%0b addr=%h cnt=%0d required all 0",
               if_gnt, ls_gnt, mem_req, mem_addr, conflict_cnt);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid} !== 5'b0 || conflict_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_release gnt=%0b%0b rvalid=%0b%0b cnt=%0d required 0",
               if_gnt, ls_gnt, if_rvalid, ls_rvalid, conflict_cnt);
    end
  endtask

  task automatic test_if_only;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(1, 32'(i * 4), 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 ||
          mem_be !== 4'hF || mem_addr !== 32'(i * 4) || mem_wdata !== '0 || conflict_cnt !== '0) begin
        n_bad++;
        $display("FAIL if_only_%0d if_gnt=%0b ls_gnt=%0b we=%0b be=%h addr=%h cnt=%0d required 1 0 0 f %h 0",
                 i, if_gnt, ls_gnt, mem_we, mem_be, mem_addr, conflict_cnt, 32'(i * 4));
      end
      q.push_back('{1'b1, memf(32'(i * 4))});
    end
    @(negedge clk);
    drain("if_only");
  endtask

  task automatic test_load_store;
    @(negedge clk);
    set_in(0, 0, 1, 0, 4'hF, 32'h100, 32'h0);
    #1;
    n_cmp++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL load_issue ls_gnt=%0b we=%0b addr=%h required 1 0 100", ls_gnt, mem_we, mem_addr);
    end
    q.push_back('{1'b0, memf(32'h100)});
    @(negedge clk);
    set_in(0, 0, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    #1;
    n_cmp++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h100 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_issue ls_gnt=%0b we=%0b be=%b addr=%h wdata=%h required 1 1 0011 100 deadbeef",
               ls_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    q.push_back('{1'b0, 32'h0});
    @(negedge clk);
    drain("load_store");
  endtask

  task automatic test_starve;
    logic [31:0] ia = 32'h1000, la = 32'h2000;
    bit want_if;
    pulse_reset();
    for (int c = 1; c <= 12; c++) begin
      set_in(1, ia, 1, 0, 4'hF, la, 0);
      #1;
      want_if = (c % 5 == 0);
      n_cmp++;
      if (if_gnt !== want_if || ls_gnt !== !want_if || mem_addr !== (want_if ? ia : la) ||
          conflict_cnt !== CW'(c - 1)) begin
        n_bad++;
        $display("FAIL starve_c%0d if_gnt=%0b ls_gnt=%0b addr=%h cnt=%0d required %0b %0b %h %0d",
                 c, if_gnt, ls_gnt, mem_addr, conflict_cnt, want_if, !want_if,
                 want_if ? ia : la, c - 1);
      end
      q.push_back('{want_if, memf(want_if ? ia : la)});
      if (want_if) ia += 4; else la += 4;
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (conflict_cnt !== CW'(12)) begin
      n_bad++;
      $display("FAIL starve_cnt conflict_cnt=%0d required 12", conflict_cnt);
    end
    drain("starve");
  endtask

  task automatic test_alternate;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) set_in(1, 32'h200 + 32'(i * 4), 0, 0, 0, 0, 0);
      else            set_in(0, 0, 1, 0, 4'hF, 32'h300 + 32'(i * 4), 0);
      #1;
      n_cmp++;
      if (if_gnt !== (i % 2 == 0) || ls_gnt !== (i % 2 == 1)) begin
        n_bad++;
        $display("FAIL alt_%0d if_gnt=%0b ls_gnt=%0b required %0b %0b",
                 i, if_gnt, ls_gnt, i % 2 == 0, i % 2 == 1);
      end
      if (i % 2 == 0) q.push_back('{1'b1, memf(32'h200 + 32'(i * 4))});
      else            q.push_back('{1'b0, memf(32'h300 + 32'(i * 4))});
    end
    @(negedge clk);
    drain("alternate");
  endtask

  task automatic test_reset_mid;
    bit want_if;
    pulse_reset();
    // Build up starvation, then reset right after an LS grant.
    for (int c = 1; c <= 4; c++) begin
      set_in(1, 32'h500, 1, 0, 4'hF, 32'h400 + 32'(c * 4), 0);
      #1;
      n_cmp++;
      if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL rmid_pre_c%0d ls_gnt=%0b if_gnt=%0b required 1 0", c, ls_gnt, if_gnt);
      end
      if (c < 4) begin
        q.push_back('{1'b0, memf(32'h400 + 32'(c * 4))});
        @(negedge clk);
      end
    end
    #2;
    rst = 1'b0;
    q.delete();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL rmid_drop_%0d ls_rvalid=%0b if_rvalid=%0b required 0", c, ls_rvalid, if_rvalid);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid} !== 5'b0 || conflict_cnt !== '0 ||
        ls_rdata !== '0 || if_rdata !== '0 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL rmid_release rvalid=%0b%0b mem_req=%0b cnt=%0d required 0",
               if_rvalid, ls_rvalid, mem_req, conflict_cnt);
    end
    // Starvation must restart from zero: four LS grants, then IF.
    for (int c = 1; c <= 5; c++) begin
      set_in(1, 32'h600, 1, 0, 4'hF, 32'h700 + 32'(c * 4), 0);
      #1;
      want_if = (c == 5);
      n_cmp++;
      if (if_gnt !== want_if || ls_gnt !== !want_if) begin
        n_bad++;
        $display("FAIL rmid_post_c%0d if_gnt=%0b ls_gnt=%0b required %0b %0b",
                 c, if_gnt, ls_gnt, want_if, !want_if);
      end
      q.push_back('{want_if, memf(want_if ? 32'h600 : 32'h700 + 32'(c * 4))});
      @(negedge clk);
    end
    drain("reset_mid");
  endtask

  task automatic test_saturate;
    bit want_if;
    pulse_reset();
    for (int c = 1; c <= 20; c++) begin
      set_in(1, 32'h800 + 32'(c * 4), 1, 0, 4'hF, 32'h900 + 32'(c * 4), 0);
      #1;
      want_if = (c % 5 == 0);
      n_cmp++;
      if (conflict_cnt !== CW'((c - 1 > 15) ? 15 : c - 1) || if_gnt !== want_if) begin
        n_bad++;
        $display("FAIL sat_c%0d conflict_cnt=%0d if_gnt=%0b required %0d %0b",
                 c, conflict_cnt, if_gnt, (c - 1 > 15) ? 15 : c - 1, want_if);
      end
      q.push_back('{want_if, memf(want_if ? 32'h800 + 32'(c * 4) : 32'h900 + 32'(c * 4))});
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (conflict_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_end conflict_cnt=%0d required 15", conflict_cnt);
    end
    @(negedge clk);
    set_in(1, 32'hA00, 1, 0, 4'hF, 32'hB00, 0);
    q.push_back('{1'b0, memf(32'hB00)});
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (conflict_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_hold conflict_cnt=%0d required 15", conflict_cnt);
    end
    drain("saturate");
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_if_only();
    test_load_store();
    test_starve();
    test_alternate();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
